// File: rtl/cla_sched_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead add sequencer.
package cla_sched_pkg;
    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int beats(input int width);
        return width / NIBBLE;
    endfunction
endpackage

// File: rtl/cla_nibble_sched_if.sv
// Request/response bundle between two operand sources, the add sequencer and its consumer.
interface cla_nibble_sched_if #(parameter int WIDTH = 16);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/cla_nibble_sched_nibble_cla.sv
// Combinational 4-bit carry-lookahead adder slice.
module nibble_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g, p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // All carries from generate/propagate terms, no ripple through the slice.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s    = p ^ c;
endmodule

// File: rtl/cla_nibble_sched.sv
// Round-robin arbiter plus sequencer that pushes a WIDTH-bit add through one 4-bit CLA slice,
// one nibble per cycle, and returns the result on a valid/ready response.
module cla_nibble_sched
    import cla_sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    cla_nibble_sched_if.slave   bus
);
    localparam int BEATS = beats(WIDTH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nxt;
    logic [BW-1:0]    beat;
    logic             carry_q, id_q, last_id;
    logic             grant, accept;
    logic             rsp_valid_q, rsp_id_q, rsp_cout_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic [NIBBLE-1:0] slice_s;
    logic             slice_c;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last_id;
    end

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant;
    assign accept         = bus.req0_ready | bus.req1_ready;

    nibble_cla u_slice (
        .a    (a_q[NIBBLE*beat +: NIBBLE]),
        .b    (b_q[NIBBLE*beat +: NIBBLE]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_comb begin
        sum_nxt = sum_q;
        sum_nxt[NIBBLE*beat +: NIBBLE] = slice_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_id     <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            beat        <= '0;
            carry_q     <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    a_q     <= grant ? bus.req1_a   : bus.req0_a;
                    b_q     <= grant ? bus.req1_b   : bus.req0_b;
                    carry_q <= grant ? bus.req1_cin : bus.req0_cin;
                    id_q    <= grant;
                    last_id <= grant;
                    beat    <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    sum_q   <= sum_nxt;
                    carry_q <= slice_c;
                    // Response regs are separate so the result survives the next op's RUN.
                    if (beat == BW'(BEATS-1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_sum_q   <= sum_nxt;
                        rsp_cout_q  <= slice_c;
                        rsp_id_q    <= id_q;
                        state       <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_cla_nibble_sched.sv
// Directed and randomized checks of cla_nibble_sched against a plain-arithmetic reference model.
module tb_cla_nibble_sched;
    localparam int W     = 16;
    localparam int BEATS = W / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic model_last = 1'b1;

    cla_nibble_sched_if #(.WIDTH(W)) bus ();
    cla_nibble_sched #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req1_valid = 0;
    endtask

    // Precondition: called #1 after a clock edge with the DUT idle.
    task automatic issue(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input bit c0,
                         input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input bit c1,
                         input int hold);
        int g, n;
        logic [W:0] e;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_cin = c0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_cin = c1;
        g = (v0 && v1) ? int'(!model_last) : int'(v1);
        e = (g == 1) ? ref_add(a1, b1, c1) : ref_add(a0, b0, c0);
        #1;
        check("ready0", bus.req0_ready, (g == 0));
        check("ready1", bus.req1_ready, (g == 1));
        @(posedge clk); #1;
        model_last = g[0];
        if (g == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
        check("busy_run", bus.busy, 1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            check("no_ready_busy", {bus.req0_ready, bus.req1_ready}, 0);
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, BEATS);
        check("rsp_sum", bus.rsp_sum, e[W-1:0]);
        check("rsp_cout", bus.rsp_cout, e[W]);
        check("rsp_id", bus.rsp_id, g);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_sum", bus.rsp_sum, e[W-1:0]);
            check("hold_id", bus.rsp_id, g);
            check("hold_busy", bus.busy, 1);
            check("hold_ready", {bus.req0_ready, bus.req1_ready}, 0);
        end
        bus.rsp_ready = 1;
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        check("post_valid", bus.rsp_valid, 0);
        check("post_busy", bus.busy, 0);
        check("post_sum_held", {bus.rsp_cout, bus.rsp_sum}, e);
        idle_inputs();
    endtask

    initial begin
        int seen, v;
        int acc[$];
        bus.rsp_ready = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0;
        bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0;
        idle_inputs();

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_sum", bus.rsp_sum, 0);
        check("rst_cout", bus.rsp_cout, 0);
        check("rst_id", bus.rsp_id, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
        rst = 0;
        @(posedge clk); #1;

        issue(1, 16'h1234, 16'h0FED, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 1, 16'hFFFF, 16'h0000, 1, 0);
        repeat (3) issue(1, 16'h0001, 16'h0001, 0, 1, 16'h8000, 16'h8000, 0, 0);
        issue(1, 16'hCAFE, 16'h3502, 1, 0, 0, 0, 0, 3);

        for (int i = 0; i < 30; i++) begin
            v = $urandom_range(1, 3);
            issue(v[0], W'($urandom), W'($urandom), 1'($urandom), v[1], W'($urandom), W'($urandom),
                  1'($urandom), $urandom_range(0, 2));
        end

        // Reset while the slice is on beat 2 of a req0 op.
        issue_start: begin
            bus.req0_valid = 1; bus.req0_a = 16'h7777; bus.req0_b = 16'h1111; bus.req0_cin = 0;
            @(posedge clk); #1;
            bus.req0_valid = 0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1;
            @(posedge clk); #1;
            rst = 0;
            model_last = 1'b1;
            check("mid_rst_busy", bus.busy, 0);
            check("mid_rst_valid", bus.rsp_valid, 0);
            check("mid_rst_sum", bus.rsp_sum, 0);
            seen = 0;
            repeat (8) begin
                @(posedge clk); #1;
                if (bus.rsp_valid) seen++;
            end
            check("dropped_op", seen, 0);
        end
        issue(1, 16'h0001, 16'h0001, 0, 1, 16'h8000, 16'h8000, 0, 0);
        issue(0, 0, 0, 0, 1, 16'h00FF, 16'h0001, 0, 0);

        // Streaming with the consumer always ready.
        bus.rsp_ready = 1;
        bus.req1_valid = 1; bus.req1_a = 16'hABCD; bus.req1_b = 16'h1234; bus.req1_cin = 0;
        for (int i = 0; i < 45; i++) begin
            if (bus.req1_ready) acc.push_back(cyc);
            if (bus.rsp_valid) begin
                check("stream_sum", bus.rsp_sum, 16'hBE01);
                check("stream_cout", bus.rsp_cout, 0);
                check("stream_id", bus.rsp_id, 1);
            end
            @(posedge clk); #1;
        end
        check("stream_accepts", acc.size() >= 6, 1);
        for (int i = 1; i < acc.size(); i++) check("stream_gap", acc[i] - acc[i-1], BEATS + 2);
        bus.req1_valid = 0;
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
